// File: rtl/gray_counter_enc.sv
// Loadable up/down binary counter whose state is also published as registered Gray code.
// It provides a per-bit Gray change mask, a wrap-around pulse and a live terminal-count flag.
module gray_counter_enc #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         up,
   input  logic         load,
   input  logic [W-1:0] din,
   output logic [W-1:0] bin,
   output logic [W-1:0] gray,
   output logic [W-1:0] chg,
   output logic         wrap,
   output logic         tc
);

   localparam logic [W-1:0] MaxVal = '1;
   localparam logic [W-1:0] ZeroVal = '0;
   localparam logic [W-1:0] OneVal = {{(W-1){1'b0}}, 1'b1};

   function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [W-1:0] binQ, binD;
   logic [W-1:0] grayQ, grayD;
   logic [W-1:0] chgQ, chgD;
   logic         wrapQ, wrapD;

   // Gray code is derived from the next binary value, so bin and gray always line up.
   always_comb begin
      binD  = binQ;
      wrapD = 1'b0;
      if (load) begin
         binD = din;
      end else if (en) begin
         if (up) begin
            binD  = binQ + OneVal;
            wrapD = (binQ == MaxVal);
         end else begin
            binD  = binQ - OneVal;
            wrapD = (binQ == ZeroVal);
         end
      end
      grayD = bin2gray(binD);
      chgD  = grayQ ^ grayD;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         binQ  <= '0;
         grayQ <= '0;
         chgQ  <= '0;
         wrapQ <= 1'b0;
      end else begin
         binQ  <= binD;
         grayQ <= grayD;
         chgQ  <= chgD;
         wrapQ <= wrapD;
      end
   end

   assign bin  = binQ;
   assign gray = grayQ;
   assign chg  = chgQ;
   assign wrap = wrapQ;
   // Terminal count follows the live direction input, independent of en.
   assign tc   = up ? (binQ == MaxVal) : (binQ == ZeroVal);

endmodule

// File: tb/tb_gray_counter_enc.sv
// Self-checking bench for gray_counter_enc: an integer reference model checked every cycle,
// plus hand-computed expectations along the directed sequence.
module tb_gray_counter_enc;

   localparam int W = 4;
   localparam int Modulus = 1 << W;

   logic         clk;
   logic         rst;
   logic         en;
   logic         up;
   logic         load;
   logic [W-1:0] din;
   logic [W-1:0] bin;
   logic [W-1:0] gray;
   logic [W-1:0] chg;
   logic         wrap;
   logic         tc;

   int testsRun = 0;
   int testsFailed = 0;

   int mBin = 0;
   int mGray = 0;
   int mChg = 0;
   int mWrap = 0;
   bit modelValid = 1'b0;

   logic [W-1:0] upGray [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                                 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                 4'b1011, 4'b1001, 4'b1000, 4'b0000};

   gray_counter_enc #(.W(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .up   (up),
      .load (load),
      .din  (din),
      .bin  (bin),
      .gray (gray),
      .chg  (chg),
      .wrap (wrap),
      .tc   (tc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int toGray(input int b);
      return b ^ (b >> 1);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic l, input logic e, input logic u,
                                input logic [W-1:0] d);
      #1;
      rst  = r;
      load = l;
      en   = e;
      up   = u;
      din  = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reference model: integer arithmetic modulo 2^W following the priority rst > load > en > hold.
   always @(posedge clk) begin
      int nextBin;
      int nextGray;
      if (rst) begin
         mBin = 0; mGray = 0; mChg = 0; mWrap = 0;
         modelValid = 1'b1;
      end else begin
         nextBin = mBin;
         mWrap = 0;
         if (load) begin
            nextBin = int'(din);
         end else if (en) begin
            if (up) begin
               nextBin = (mBin + 1) % Modulus;
               mWrap = (mBin == Modulus - 1) ? 1 : 0;
            end else begin
               nextBin = (mBin + Modulus - 1) % Modulus;
               mWrap = (mBin == 0) ? 1 : 0;
            end
         end
         nextGray = toGray(nextBin);
         mChg = mGray ^ nextGray;
         mBin = nextBin;
         mGray = nextGray;
      end
   end

   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("model_bin", 32'(bin), 32'(mBin));
         checkOutput("model_gray", 32'(gray), 32'(mGray));
         checkOutput("model_chg", 32'(chg), 32'(mChg));
         checkOutput("model_wrap", 32'(wrap), 32'(mWrap));
         checkOutput("model_tc", 32'(tc),
                     32'((up && mBin == Modulus - 1) || (!up && mBin == 0)));
      end
   end

   initial begin
      rst = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; din = '0;
      @(negedge clk);

      applyStimulus(1, 0, 0, 1, 4'h0);
      checkOutput("reset_bin", 32'(bin), 32'h0);
      checkOutput("reset_gray", 32'(gray), 32'h0);
      checkOutput("reset_chg", 32'(chg), 32'h0);
      checkOutput("reset_wrap", 32'(wrap), 32'h0);

      // Full up-count cycle through all sixteen Gray codes.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 0, 1, 1, 4'h0);
         checkOutput("up_gray", 32'(gray), 32'(upGray[i]));
         checkOutput("up_chg_onehot", 32'($countones(chg)), 32'd1);
         checkOutput("up_wrap", 32'(wrap), (i == 15) ? 32'd1 : 32'd0);
      end
      checkOutput("up_last_chg", 32'(chg), 32'b1000);

      // Down step from zero wraps to all ones.
      applyStimulus(1, 0, 0, 1, 4'h0);
      #1; up = 1'b0;
      #1; checkOutput("tc_down_at_zero", 32'(tc), 32'd1);
      applyStimulus(0, 0, 1, 0, 4'h0);
      checkOutput("down_wrap_bin", 32'(bin), 32'b1111);
      checkOutput("down_wrap_gray", 32'(gray), 32'b1000);
      checkOutput("down_wrap_pulse", 32'(wrap), 32'd1);

      // Load wins over en; then loading the same value changes nothing.
      applyStimulus(1, 0, 0, 1, 4'h0);
      applyStimulus(0, 1, 1, 1, 4'b1001);
      checkOutput("load_bin", 32'(bin), 32'b1001);
      checkOutput("load_gray", 32'(gray), 32'b1101);
      checkOutput("load_chg", 32'(chg), 32'b1101);
      checkOutput("load_wrap", 32'(wrap), 32'd0);
      applyStimulus(0, 1, 0, 0, 4'b1001);
      checkOutput("reload_chg", 32'(chg), 32'd0);

      // Hold at 0110.
      applyStimulus(0, 1, 0, 1, 4'b0110);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 1, 4'b0000);
         checkOutput("hold_gray", 32'(gray), 32'b0101);
         checkOutput("hold_chg", 32'(chg), 32'd0);
         checkOutput("hold_wrap", 32'(wrap), 32'd0);
      end

      // Reset overrides a simultaneous load while counting.
      applyStimulus(0, 1, 0, 1, 4'b0011);
      applyStimulus(0, 0, 1, 1, 4'b0000);
      checkOutput("pre_rst_bin", 32'(bin), 32'b0100);
      applyStimulus(1, 1, 1, 1, 4'b1111);
      checkOutput("rst_over_load_bin", 32'(bin), 32'd0);
      checkOutput("rst_over_load_gray", 32'(gray), 32'd0);
      checkOutput("rst_over_load_chg", 32'(chg), 32'd0);

      // Direction reversal with no dead cycle.
      applyStimulus(0, 1, 0, 1, 4'b0111);
      applyStimulus(0, 0, 1, 1, 4'b0000);
      checkOutput("rev_up_gray", 32'(gray), 32'b1100);
      checkOutput("rev_up_chg", 32'(chg), 32'b1000);
      applyStimulus(0, 0, 1, 0, 4'b0000);
      checkOutput("rev_down_bin", 32'(bin), 32'b0111);
      checkOutput("rev_down_gray", 32'(gray), 32'b0100);
      checkOutput("rev_down_chg", 32'(chg), 32'b1000);

      // Multi-bit load change, then counting across both wrap points.
      applyStimulus(0, 1, 0, 1, 4'b1110);
      checkOutput("load_multi_chg", 32'(chg), 32'b1101);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 4'h0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 4'h0);
      checkOutput("mixed_bin", 32'(bin), 32'b1101);
      applyStimulus(0, 0, 0, 1, 4'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
